// File: rtl/pool_pkg.sv
// Shared types and default widths for the cue/shot producer.
package pool_pkg;

    // Shot sequencing states
    typedef enum logic [1:0] {
        AIM    = 2'd0,
        CHARGE = 2'd1,
        FIRE   = 2'd2,
        MOTION = 2'd3
    } shot_st_t;

    localparam int DEF_ANGLE_W = 6;
    localparam int DEF_POWER_W = 5;

endpackage

// File: rtl/motion_settle_detector.sv
// Declares the table settled once no ball has moved for STOP_FRAMES frames
// after a shot. Armed by the FIRE pulse, which drops the stopped flag.
module motion_settle_detector #(
    parameter int STOP_FRAMES = 8,
    parameter int NUM_BALLS   = 4
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 arm,
    input  logic [NUM_BALLS-1:0] ball_moving,
    output logic                 stopped
);

    localparam int CNT_W = (STOP_FRAMES > 1) ? $clog2(STOP_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STOP_FRAMES - 1);

    logic [CNT_W-1:0] r_still_cnt;
    logic             r_stopped;
    logic             r_arm_d;
    logic             w_any_moving;
    logic             w_still_frame;

    assign w_any_moving  = (ball_moving != '0);
    // The cycle after arm is the FIRE state; counting starts on entry to MOTION.
    assign w_still_frame = startOfFrame && !w_any_moving && !r_stopped && !arm && !r_arm_d;
    assign stopped       = r_stopped;

    // Delayed arm marks the FIRE cycle so the still-counter starts clean in MOTION
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_arm_d <= 1'b0;
        else         r_arm_d <= arm;
    end

    // Still-frame counter: cleared by any motion or a new shot
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_still_cnt <= '0;
        end else if (arm || r_arm_d || w_any_moving) begin
            r_still_cnt <= '0;
        end else if (w_still_frame && (r_still_cnt != LAST)) begin
            r_still_cnt <= r_still_cnt + 1'b1;
        end
    end

    // Settled flag: dropped on a shot, raised on the STOP_FRAMES-th still frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_stopped <= 1'b1;
        end else if (arm) begin
            r_stopped <= 1'b0;
        end else if (w_still_frame && (r_still_cnt == LAST)) begin
            r_stopped <= 1'b1;
        end
    end

endmodule

// File: rtl/cue_shot_generator.sv
// Turns player keys into an aimed, powered shot and reports when the
// table has settled again. Holds the shot FSM, power accumulator,
// rotation frame counter and aim angle.
module cue_shot_generator
    import pool_pkg::*;
#(
    parameter int ANGLE_W     = DEF_ANGLE_W,
    parameter int POWER_W     = DEF_POWER_W,
    parameter int MAX_POWER   = 31,
    parameter int ROT_FRAMES  = 4,
    parameter int STOP_FRAMES = 8,
    parameter int NUM_BALLS   = 4
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 cueEnable,
    input  logic                 resetCueN,
    input  logic                 key_left,
    input  logic                 key_right,
    input  logic                 key_shoot,
    input  logic [NUM_BALLS-1:0] ball_moving,
    output logic                 shot_made,
    output logic [POWER_W-1:0]   shot_power,
    output logic [ANGLE_W-1:0]   cue_angle,
    output logic                 charging,
    output logic                 all_balls_stopped
);

    localparam int ROT_W = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;
    localparam logic [ROT_W-1:0]   ROT_LAST = ROT_W'(ROT_FRAMES - 1);
    localparam logic [POWER_W-1:0] PWR_MAX  = POWER_W'(MAX_POWER);

    shot_st_t           r_state;
    shot_st_t           w_next_state;
    logic [POWER_W-1:0] r_power;
    logic [POWER_W-1:0] r_shot_power;
    logic               r_shot_made;
    logic               r_charging;
    logic [ROT_W-1:0]   r_rot_cnt;
    logic [ANGLE_W-1:0] r_angle;
    logic               w_fire_entry;
    logic               w_rot_active;
    logic               w_rot_step;
    logic               w_stopped;

    // Saturating +1 so a held shoot key never wraps the power bar
    function automatic logic [POWER_W-1:0] f_power_inc(input logic [POWER_W-1:0] v);
        return (v >= PWR_MAX) ? PWR_MAX : v + 1'b1;
    endfunction

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= AIM;
        else         r_state <= w_next_state;
    end

    // Next-state logic; resetCueN overrides every transition
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            AIM:    if (key_shoot && cueEnable) w_next_state = CHARGE;
            CHARGE: begin
                if (!cueEnable)     w_next_state = AIM;
                else if (!key_shoot) w_next_state = (r_power != '0) ? FIRE : AIM;
            end
            FIRE:   w_next_state = MOTION;
            MOTION: if (w_stopped) w_next_state = AIM;
            default: w_next_state = AIM;
        endcase
        if (!resetCueN) w_next_state = AIM;
    end

    assign w_fire_entry = (w_next_state == FIRE) && (r_state != FIRE);

    // Power accumulator: cleared on entering CHARGE or leaving it without a shot
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_power <= '0;
        end else if (!resetCueN) begin
            r_power <= '0;
        end else if (r_state != CHARGE && w_next_state == CHARGE) begin
            r_power <= '0;
        end else if (r_state == CHARGE && w_next_state == AIM) begin
            r_power <= '0;
        end else if (r_state == CHARGE && startOfFrame && key_shoot && cueEnable) begin
            r_power <= f_power_inc(r_power);
        end
    end

    // Shot outputs: pulse and latched power registered on the edge entering FIRE
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_shot_made  <= 1'b0;
            r_shot_power <= '0;
            r_charging   <= 1'b0;
        end else begin
            r_shot_made <= w_fire_entry;
            if (w_fire_entry) r_shot_power <= r_power;
            r_charging <= (w_next_state == CHARGE);
        end
    end

    // Rotation only while aiming with exactly one direction key; shoot takes priority
    assign w_rot_active = (r_state == AIM) && cueEnable && resetCueN && !key_shoot &&
                          (key_left ^ key_right);
    assign w_rot_step   = w_rot_active && startOfFrame && (r_rot_cnt == ROT_LAST);

    // Rotation frame counter
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rot_cnt <= '0;
        end else if (!w_rot_active) begin
            r_rot_cnt <= '0;
        end else if (startOfFrame) begin
            r_rot_cnt <= (r_rot_cnt == ROT_LAST) ? '0 : r_rot_cnt + 1'b1;
        end
    end

    // Aim angle, wrapping modulo 2**ANGLE_W
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_angle <= '0;
        end else if (w_rot_step) begin
            r_angle <= key_right ? r_angle + 1'b1 : r_angle - 1'b1;
        end
    end

    motion_settle_detector #(
        .STOP_FRAMES (STOP_FRAMES),
        .NUM_BALLS   (NUM_BALLS)
    ) u_settle (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .arm          (w_fire_entry),
        .ball_moving  (ball_moving),
        .stopped      (w_stopped)
    );

    assign shot_made         = r_shot_made;
    assign shot_power        = r_shot_power;
    assign cue_angle         = r_angle;
    assign charging          = r_charging;
    assign all_balls_stopped = w_stopped;

endmodule

// File: tb/tb_cue_shot_generator.sv
// Directed bench for cue_shot_generator: shot firing, power saturation,
// rotation, settle detection, aborts and asynchronous reset.
module tb_cue_shot_generator;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       cueEnable = 1'b1;
    logic       resetCueN = 1'b1;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic       key_shoot = 1'b0;
    logic [3:0] ball_moving = 4'b0000;
    logic       shot_made;
    logic [4:0] shot_power;
    logic [5:0] cue_angle;
    logic       charging;
    logic       all_balls_stopped;

    int checks = 0;
    int errors = 0;
    int shot_cnt = 0;
    int base;

    cue_shot_generator dut (
        .clk               (clk),
        .resetN            (resetN),
        .startOfFrame      (startOfFrame),
        .cueEnable         (cueEnable),
        .resetCueN         (resetCueN),
        .key_left          (key_left),
        .key_right         (key_right),
        .key_shoot         (key_shoot),
        .ball_moving       (ball_moving),
        .shot_made         (shot_made),
        .shot_power        (shot_power),
        .cue_angle         (cue_angle),
        .charging          (charging),
        .all_balls_stopped (all_balls_stopped)
    );

    always #5 clk = ~clk;

    // Count every shot_made pulse
    always @(negedge clk) begin
        if (shot_made) shot_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int n);
        repeat (n) begin
            startOfFrame = 1'b1;
            tick(1);
            startOfFrame = 1'b0;
            tick(2);
        end
    endtask

    task automatic settle();
        ball_moving = 4'b0000;
        frame(10);
        tick(2);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        tick(3);
        checks++; if (shot_made !== 1'b0) begin errors++; $display("FAIL reset_shot_made got %b exp 0", shot_made); end
        checks++; if (shot_power !== 5'd0) begin errors++; $display("FAIL reset_shot_power got %0d exp 0", shot_power); end
        checks++; if (cue_angle !== 6'd0) begin errors++; $display("FAIL reset_cue_angle got %0d exp 0", cue_angle); end
        checks++; if (charging !== 1'b0) begin errors++; $display("FAIL reset_charging got %b exp 0", charging); end
        checks++; if (all_balls_stopped !== 1'b1) begin errors++; $display("FAIL reset_stopped got %b exp 1", all_balls_stopped); end
        resetN = 1'b1;
        tick(2);
    endtask

    task automatic test_fire();
        base = shot_cnt;
        key_shoot = 1'b1;
        tick(1);
        checks++; if (charging !== 1'b1) begin errors++; $display("FAIL fire_charging got %b exp 1", charging); end
        frame(10);
        key_shoot = 1'b0;
        tick(1);
        checks++; if (shot_made !== 1'b1) begin errors++; $display("FAIL fire_pulse got %b exp 1", shot_made); end
        checks++; if (shot_power !== 5'd10) begin errors++; $display("FAIL fire_power got %0d exp 10", shot_power); end
        checks++; if (all_balls_stopped !== 1'b0) begin errors++; $display("FAIL fire_stopped got %b exp 0", all_balls_stopped); end
        tick(1);
        checks++; if (shot_made !== 1'b0) begin errors++; $display("FAIL fire_pulse_drop got %b exp 0", shot_made); end
        checks++; if (charging !== 1'b0) begin errors++; $display("FAIL fire_charging_drop got %b exp 0", charging); end
        settle();
        checks++; if (shot_cnt - base !== 1) begin errors++; $display("FAIL fire_pulse_count got %0d exp 1", shot_cnt - base); end
    endtask

    task automatic test_saturation();
        key_shoot = 1'b1;
        tick(1);
        frame(40);
        key_shoot = 1'b0;
        tick(1);
        checks++; if (shot_made !== 1'b1) begin errors++; $display("FAIL sat_pulse got %b exp 1", shot_made); end
        checks++; if (shot_power !== 5'd31) begin errors++; $display("FAIL sat_power got %0d exp 31", shot_power); end
        settle();
        base = shot_cnt;
        key_shoot = 1'b1;
        tick(1);
        key_shoot = 1'b0;
        tick(4);
        checks++; if (shot_cnt !== base) begin errors++; $display("FAIL tap_no_shot got %0d pulses exp 0", shot_cnt - base); end
        checks++; if (charging !== 1'b0) begin errors++; $display("FAIL tap_charging got %b exp 0", charging); end
        checks++; if (shot_power !== 5'd31) begin errors++; $display("FAIL tap_power_held got %0d exp 31", shot_power); end
    endtask

    task automatic test_rotation();
        key_left = 1'b1;
        frame(3);
        checks++; if (cue_angle !== 6'd0) begin errors++; $display("FAIL rot_left_3 got %0d exp 0", cue_angle); end
        frame(1);
        checks++; if (cue_angle !== 6'd63) begin errors++; $display("FAIL rot_left_wrap got %0d exp 63", cue_angle); end
        key_left = 1'b0;
        key_right = 1'b1;
        frame(8);
        checks++; if (cue_angle !== 6'd1) begin errors++; $display("FAIL rot_right_wrap got %0d exp 1", cue_angle); end
        key_left = 1'b1;
        frame(8);
        checks++; if (cue_angle !== 6'd1) begin errors++; $display("FAIL rot_both got %0d exp 1", cue_angle); end
        key_left = 1'b0;
        cueEnable = 1'b0;
        frame(8);
        checks++; if (cue_angle !== 6'd1) begin errors++; $display("FAIL rot_disabled got %0d exp 1", cue_angle); end
        key_right = 1'b0;
        cueEnable = 1'b1;
        tick(2);
    endtask

    task automatic test_settle();
        key_shoot = 1'b1;
        tick(1);
        frame(3);
        key_shoot = 1'b0;
        tick(2);
        ball_moving = 4'b0010;
        frame(20);
        checks++; if (all_balls_stopped !== 1'b0) begin errors++; $display("FAIL settle_moving got %b exp 0", all_balls_stopped); end
        ball_moving = 4'b0000;
        frame(4);
        checks++; if (all_balls_stopped !== 1'b0) begin errors++; $display("FAIL settle_4 got %b exp 0", all_balls_stopped); end
        ball_moving = 4'b0010;
        frame(1);
        ball_moving = 4'b0000;
        frame(7);
        checks++; if (all_balls_stopped !== 1'b0) begin errors++; $display("FAIL settle_glitch_7 got %b exp 0", all_balls_stopped); end
        frame(1);
        checks++; if (all_balls_stopped !== 1'b1) begin errors++; $display("FAIL settle_8 got %b exp 1", all_balls_stopped); end
        checks++; if (shot_power !== 5'd3) begin errors++; $display("FAIL settle_power got %0d exp 3", shot_power); end
        tick(2);
    endtask

    task automatic test_abort();
        base = shot_cnt;
        key_shoot = 1'b1;
        tick(1);
        frame(12);
        cueEnable = 1'b0;
        tick(1);
        checks++; if (charging !== 1'b0) begin errors++; $display("FAIL abort_charging got %b exp 0", charging); end
        key_shoot = 1'b0;
        cueEnable = 1'b1;
        tick(4);
        checks++; if (shot_cnt !== base) begin errors++; $display("FAIL abort_no_shot got %0d pulses exp 0", shot_cnt - base); end
        ball_moving = 4'b0010;
        key_shoot = 1'b1;
        tick(1);
        frame(2);
        key_shoot = 1'b0;
        tick(2);
        key_right = 1'b1;
        frame(4);
        checks++; if (cue_angle !== 6'd1) begin errors++; $display("FAIL motion_no_rot got %0d exp 1", cue_angle); end
        key_right = 1'b0;
        resetCueN = 1'b0;
        tick(1);
        resetCueN = 1'b1;
        checks++; if (cue_angle !== 6'd1) begin errors++; $display("FAIL cuereset_angle got %0d exp 1", cue_angle); end
        checks++; if (shot_power !== 5'd2) begin errors++; $display("FAIL cuereset_power got %0d exp 2", shot_power); end
        key_right = 1'b1;
        frame(4);
        key_right = 1'b0;
        checks++; if (cue_angle !== 6'd2) begin errors++; $display("FAIL cuereset_aim got %0d exp 2", cue_angle); end
        settle();
    endtask

    task automatic test_async_reset();
        base = shot_cnt;
        key_shoot = 1'b1;
        tick(1);
        frame(5);
        #2;
        resetN = 1'b0;
        #1;
        checks++; if (charging !== 1'b0) begin errors++; $display("FAIL areset_charging got %b exp 0", charging); end
        checks++; if (shot_power !== 5'd0) begin errors++; $display("FAIL areset_power got %0d exp 0", shot_power); end
        checks++; if (cue_angle !== 6'd0) begin errors++; $display("FAIL areset_angle got %0d exp 0", cue_angle); end
        checks++; if (all_balls_stopped !== 1'b1) begin errors++; $display("FAIL areset_stopped got %b exp 1", all_balls_stopped); end
        checks++; if (shot_made !== 1'b0) begin errors++; $display("FAIL areset_shot_made got %b exp 0", shot_made); end
        tick(1);
        key_shoot = 1'b0;
        tick(1);
        resetN = 1'b1;
        tick(4);
        checks++; if (shot_cnt !== base) begin errors++; $display("FAIL areset_no_shot got %0d pulses exp 0", shot_cnt - base); end
    endtask

    initial begin
        test_reset();
        test_fire();
        test_saturation();
        test_rotation();
        test_settle();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
